ula_bus_sequencer: RTL and testbench

ULA_BUS_SEQUENCER -- requirements
Module: ula_bus_sequencer

---
 rtl/ula_pkg.sv | 23 ++
 rtl/ula_settle_timer.sv | 25 ++
 rtl/ula_bus_sequencer.sv | 111 +++++++++++
 tb/tb_ula_bus_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared state type, widths and unit indices for the ULA bus sequencer.
package ula_pkg;

  localparam int ULA_BUS_W  = 9;
  localparam int ULA_DATA_W = 8;

  localparam logic [1:0] UNIT_ARITH = 2'd0;
  localparam logic [1:0] UNIT_LOGIC = 2'd1;
  localparam logic [1:0] UNIT_CMP   = 2'd2;
  localparam logic [1:0] UNIT_SHIFT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRIVE,
    ST_RESP
  } ula_state_e;

  function automatic logic [3:0] unit_onehot(input logic [1:0] unit);
    unit_onehot = 4'b0001 << unit;
  endfunction

endpackage

// File: rtl/ula_settle_timer.sv
// 4-bit down-counter timing how long a ULA unit drives the shared bus.
module ula_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/ula_bus_sequencer.sv
// Sequences one request at a time onto a shared tri-state ULA result bus and
// returns the captured result through a valid/ready response channel.
module ula_bus_sequencer
  import ula_pkg::*;
#(
  parameter int SETTLE  = 1,
  parameter int N_UNITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_unit,
  input  logic [ULA_DATA_W-1:0] req_a,
  input  logic [ULA_DATA_W-1:0] req_b,
  output logic [ULA_DATA_W-1:0] ula_a,
  output logic [ULA_DATA_W-1:0] ula_b,
  output logic [N_UNITS-1:0]    ula_en,
  input  logic [ULA_BUS_W-1:0]  ula_bus,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ULA_BUS_W-1:0]  rsp_data,
  output logic [1:0]            rsp_unit,
  output logic                  busy,
  output logic [15:0]           ops_done
);

  // Counter holds SETTLE-1 on DRIVE entry so the zero flag marks the last drive cycle.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  ula_state_e            r_state;
  logic [ULA_DATA_W-1:0] r_ula_a;
  logic [ULA_DATA_W-1:0] r_ula_b;
  logic [N_UNITS-1:0]    r_ula_en;
  logic                  r_rsp_valid;
  logic [ULA_BUS_W-1:0]  r_rsp_data;
  logic [1:0]            r_rsp_unit;
  logic [15:0]           r_ops_done;

  logic w_timer_load;
  logic w_timer_dec;
  logic w_settle_zero;

  assign w_timer_load = (r_state == ST_LOAD);
  assign w_timer_dec  = (r_state == ST_DRIVE);

  ula_settle_timer u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_timer_load),
    .i_load_val (SETTLE_LOAD),
    .i_dec      (w_timer_dec),
    .o_zero     (w_settle_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ula_a     <= '0;
      r_ula_b     <= '0;
      r_ula_en    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_unit  <= '0;
      r_ops_done  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_ula_a    <= req_a;
            r_ula_b    <= req_b;
            r_rsp_unit <= req_unit;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_ula_en <= N_UNITS'(unit_onehot(r_rsp_unit));
          r_state  <= ST_DRIVE;
        end
        ST_DRIVE: begin
          // Enable drops on the capture edge, giving break-before-make to the next unit.
          if (w_settle_zero) begin
            r_rsp_data  <= ula_bus;
            r_ula_en    <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ops_done  <= r_ops_done + 16'd1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign ula_a     = r_ula_a;
  assign ula_b     = r_ula_b;
  assign ula_en    = r_ula_en;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_unit  = r_rsp_unit;
  assign ops_done  = r_ops_done;

endmodule

// File: tb/tb_ula_bus_sequencer.sv
// Bench for ula_bus_sequencer: directed cases plus randomized requests checked
// against a transaction-level model of unit results, timing and completion count.
module tb_ula_bus_sequencer;

  localparam int SETTLE = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_unit  = 2'd0;
  logic [7:0] req_a     = 8'd0;
  logic [7:0] req_b     = 8'd0;
  logic [7:0] ula_a, ula_b;
  logic [3:0] ula_en;
  logic [8:0] ula_bus;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [8:0] rsp_data;
  logic [1:0] rsp_unit;
  logic       busy;
  logic [15:0] ops_done;

  logic       req_valid1 = 1'b0;
  logic       req_ready1;
  logic [1:0] req_unit1  = 2'd0;
  logic [7:0] req_a1     = 8'd0;
  logic [7:0] req_b1     = 8'd0;
  logic [7:0] ula_a1, ula_b1;
  logic [3:0] ula_en1;
  logic [8:0] ula_bus1;
  logic       rsp_valid1;
  logic       rsp_ready1 = 1'b0;
  logic [8:0] rsp_data1;
  logic [1:0] rsp_unit1;
  logic       busy1;
  logic [15:0] ops_done1;

  int checks    = 0;
  int failures  = 0;
  int onehotErr = 0;
  int gapErr    = 0;
  int zeroRun   = 0;
  logic [3:0]  prevEn   = 4'd0;
  logic [15:0] modelOps = 16'd0;

  ula_bus_sequencer #(.SETTLE(SETTLE), .N_UNITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_unit(req_unit),
    .req_a(req_a), .req_b(req_b),
    .ula_a(ula_a), .ula_b(ula_b), .ula_en(ula_en), .ula_bus(ula_bus),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_unit(rsp_unit), .busy(busy), .ops_done(ops_done)
  );

  ula_bus_sequencer #(.SETTLE(1), .N_UNITS(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_unit(req_unit1),
    .req_a(req_a1), .req_b(req_b1),
    .ula_a(ula_a1), .ula_b(ula_b1), .ula_en(ula_en1), .ula_bus(ula_bus1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
    .rsp_unit(rsp_unit1), .busy(busy1), .ops_done(ops_done1)
  );

  // Unit behaviour; no result can equal 9'h1FF, the pattern of an undriven bus.
  function automatic logic [8:0] unitResult(input logic [1:0] unit, input logic [7:0] a,
                                            input logic [7:0] b);
    case (unit)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a ^ b};
      2'd2:    return {8'd0, (a < b)};
      default: return {a, 1'b0};
    endcase
  endfunction

  always_comb begin
    case (ula_en)
      4'b0001: ula_bus = unitResult(2'd0, ula_a, ula_b);
      4'b0010: ula_bus = unitResult(2'd1, ula_a, ula_b);
      4'b0100: ula_bus = unitResult(2'd2, ula_a, ula_b);
      4'b1000: ula_bus = unitResult(2'd3, ula_a, ula_b);
      default: ula_bus = 9'h1FF;
    endcase
  end

  assign ula_bus1 = (ula_en1 == 4'b0100) ? 9'h160 : 9'h1FF;

  always @(negedge clk) begin
    if (!$onehot0(ula_en))  onehotErr++;
    if (!$onehot0(ula_en1)) onehotErr++;
    if (ula_en != 4'd0) begin
      if (prevEn != 4'd0 && prevEn != ula_en) gapErr++;
      if (zeroRun == 1) gapErr++;
      zeroRun = 0;
    end else if (zeroRun < 1000) begin
      zeroRun++;
    end
    prevEn = ula_en;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One full transaction on the main instance, entered and left at a falling edge.
  task automatic applyStimulus(input logic [1:0] unit, input logic [7:0] a, input logic [7:0] b,
                               input int holdCycles, input bit junk);
    logic [3:0] expEn;
    logic [8:0] expData;
    int k, enCycles, holdErr, stabErr;
    expEn   = 4'b0001 << unit;
    expData = unitResult(unit, a, b);
    checkOutput("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_unit = unit; req_a = a; req_b = b;
    rsp_ready = (holdCycles == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = junk; req_unit = ~unit; req_a = ~a; req_b = ~b;
    checkOutput("load_en_zero", ula_en, 0);
    checkOutput("busy_after_accept", busy, 1);
    k = 0; enCycles = 0; holdErr = 0;
    while (!rsp_valid && k < 40) begin
      if (ula_en == expEn) enCycles++;
      if (ula_a !== a || ula_b !== b || rsp_unit !== unit || req_ready !== 1'b0) holdErr++;
      @(negedge clk);
      k++;
    end
    checkOutput("rsp_latency", k, SETTLE + 1);
    checkOutput("drive_cycles", enCycles, SETTLE);
    checkOutput("operand_hold", holdErr, 0);
    checkOutput("rsp_data", rsp_data, expData);
    checkOutput("rsp_unit", rsp_unit, unit);
    checkOutput("resp_en_zero", ula_en, 0);
    stabErr = 0;
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== expData || rsp_unit !== unit ||
          req_ready !== 1'b0 || ula_a !== a || ula_b !== b) stabErr++;
    end
    if (holdCycles > 0) checkOutput("rsp_hold_stable", stabErr, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    modelOps = modelOps + 16'd1;
    checkOutput("rsp_valid_drop", rsp_valid, 0);
    checkOutput("ops_done", ops_done, modelOps);
    checkOutput("req_ready_back", req_ready, 1);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_ula_en", ula_en, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_rsp_unit", rsp_unit, 0);
    checkOutput("rst_ula_a", ula_a, 0);
    checkOutput("rst_ula_b", ula_b, 0);
    checkOutput("rst_ops_done", ops_done, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_req_ready", req_ready, 1);
    rst_n = 1'b1;

    applyStimulus(2'd1, 8'h3C, 8'hA5, 0, 1'b0);
    applyStimulus(2'd3, 8'h81, 8'h7E, 0, 1'b0);
    checkOutput("ops_done_two", ops_done, 2);
    applyStimulus(2'd0, 8'hFF, 8'hFF, 0, 1'b1);
    applyStimulus(2'd2, 8'h10, 8'h20, 5, 1'b1);

    req_valid1 = 1'b1; req_unit1 = 2'd2; req_a1 = 8'h05; req_b1 = 8'h05;
    checkOutput("s1_req_ready", req_ready1, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid1 = 1'b0;
    checkOutput("s1_load_en", ula_en1, 0);
    @(negedge clk);
    checkOutput("s1_en_e1", ula_en1, 4'b0100);
    checkOutput("s1_no_rsp_e1", rsp_valid1, 0);
    @(negedge clk);
    checkOutput("s1_en_e2", ula_en1, 0);
    checkOutput("s1_rsp_valid_e2", rsp_valid1, 1);
    checkOutput("s1_rsp_data", rsp_data1, 9'h160);
    checkOutput("s1_rsp_unit", rsp_unit1, 2);
    rsp_ready1 = 1'b1;
    @(negedge clk);
    checkOutput("s1_rsp_drop", rsp_valid1, 0);
    checkOutput("s1_ops_done", ops_done1, 1);
    rsp_ready1 = 1'b0;

    for (int n = 0; n < 40; n++) begin
      applyStimulus(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    req_valid = 1'b1; req_unit = 2'd3; req_a = 8'h12; req_b = 8'h34;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_reset_drive", ula_en, 4'b1000);
    #1 rst_n = 1'b0;
    #1;
    modelOps = 16'd0;
    checkOutput("async_rst_en", ula_en, 0);
    checkOutput("async_rst_ops", ops_done, modelOps);
    checkOutput("async_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    checkOutput("rst_no_rsp", rsp_valid, 0);
    rst_n = 1'b1;
    applyStimulus(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 0, 1'b0);

    force dut.r_ops_done = 16'hFFFE;
    #1 release dut.r_ops_done;
    modelOps = 16'hFFFE;
    applyStimulus(2'd1, 8'hF0, 8'h0F, 0, 1'b0);
    applyStimulus(2'd3, 8'hC3, 8'h11, 1, 1'b0);
    checkOutput("ops_wrap_zero", ops_done, 16'h0000);

    checkOutput("onehot_violations", onehotErr, 0);
    checkOutput("en_gap_violations", gapErr, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
